// File: rtl/traffic_light_driver_if.sv
// Phase-in / lamps-out bundle between the sequencer and the lamp driver.
interface traffic_light_driver_if;
  logic [1:0] state;      // 0=NS_GREEN 1=NS_YELLOW 2=EW_GREEN 3=EW_YELLOW
  logic       fault_clr;  // single-cycle request to leave fault mode
  logic [2:0] ns_lamp;    // {red,yellow,green}
  logic [2:0] ew_lamp;    // {red,yellow,green}
  logic       fault;

  // Sequencer side
  modport master (
    output state, fault_clr,
    input  ns_lamp, ew_lamp, fault
  );

  // Lamp-driver side
  modport slave (
    input  state, fault_clr,
    output ns_lamp, ew_lamp, fault
  );
endinterface

// File: rtl/traffic_light_driver.sv
// Registered lamp driver: decodes the sequencer phase, inserts all-red clearance
// before each green, and latches a flashing-red fault on any illegal phase jump.
module traffic_light_driver #(
  parameter int unsigned ALL_RED_CYCLES = 2,  // 0..255
  parameter int unsigned BLINK_HALF     = 4   // 1..255
) (
  input logic                   clk,
  input logic                   rst,
  traffic_light_driver_if.slave bus
);

  typedef enum logic [1:0] {ModeRun, ModeClear, ModeFault} mode_e;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  localparam bit         HasClear  = (ALL_RED_CYCLES != 0);
  localparam logic [7:0] ClrInit   = HasClear ? 8'(ALL_RED_CYCLES - 1) : 8'd0;
  localparam logic [7:0] BlinkInit = 8'(BLINK_HALF - 1);
  // Mode entered after reset or fault exit; skips CLEAR when no clearance is configured.
  localparam mode_e      ModeStart = HasClear ? ModeClear : ModeRun;

  mode_e      mode_q, mode_d;
  logic [1:0] prev_q, prev_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       fault_q, fault_d;

  logic [1:0] prev_inc;
  logic       legal;
  logic       into_green;
  logic [5:0] run_lamps;

  // Phase code to {ns,ew} lamp pattern.
  function automatic logic [5:0] decode(input logic [1:0] st);
    logic [5:0] lamps;
    unique case (st)
      2'd0:    lamps = {LampGrn, LampRed};
      2'd1:    lamps = {LampYel, LampRed};
      2'd2:    lamps = {LampRed, LampGrn};
      default: lamps = {LampRed, LampYel};
    endcase
    return lamps;
  endfunction

  // Sequencer only ever holds its phase or advances by one (mod 4).
  always_comb begin
    prev_inc   = prev_q + 2'd1;
    legal      = (bus.state == prev_q) || (bus.state == prev_inc);
    into_green = ((prev_q == 2'd1) && (bus.state == 2'd2)) ||
                 ((prev_q == 2'd3) && (bus.state == 2'd0));
    run_lamps  = decode(bus.state);
  end

  // Next-state and lamp computation for the RUN / CLEAR / FAULT modes.
  always_comb begin
    mode_d      = mode_q;
    prev_d      = bus.state;
    clr_cnt_d   = clr_cnt_q;
    blink_cnt_d = blink_cnt_q;
    ns_d        = ns_q;
    ew_d        = ew_q;
    fault_d     = fault_q;

    unique case (mode_q)
      ModeRun: begin
        if (!legal) begin
          mode_d      = ModeFault;
          ns_d        = LampRed;
          ew_d        = LampRed;
          fault_d     = 1'b1;
          blink_cnt_d = BlinkInit;
        end else if (into_green && HasClear) begin
          mode_d    = ModeClear;
          ns_d      = LampRed;
          ew_d      = LampRed;
          clr_cnt_d = ClrInit;
        end else begin
          {ns_d, ew_d} = run_lamps;
        end
      end

      ModeClear: begin
        if (!legal) begin
          mode_d      = ModeFault;
          ns_d        = LampRed;
          ew_d        = LampRed;
          fault_d     = 1'b1;
          blink_cnt_d = BlinkInit;
        end else if (clr_cnt_q != 8'd0) begin
          // Legal phase changes here do not restart the count.
          clr_cnt_d = clr_cnt_q - 8'd1;
          ns_d      = LampRed;
          ew_d      = LampRed;
        end else begin
          mode_d       = ModeRun;
          {ns_d, ew_d} = run_lamps;
        end
      end

      ModeFault: begin
        if (bus.fault_clr && (bus.state == 2'd0)) begin
          mode_d    = ModeStart;
          fault_d   = 1'b0;
          clr_cnt_d = ClrInit;
          if (HasClear) begin
            ns_d = LampRed;
            ew_d = LampRed;
          end else begin
            {ns_d, ew_d} = run_lamps;
          end
        end else begin
          // Both red bits blink in lock-step; yellow/green stay dark.
          ns_d = {ns_q[2], 2'b00};
          ew_d = {ns_q[2], 2'b00};
          if (blink_cnt_q == 8'd0) begin
            ns_d[2]     = ~ns_q[2];
            ew_d[2]     = ~ns_q[2];
            blink_cnt_d = BlinkInit;
          end else begin
            blink_cnt_d = blink_cnt_q - 8'd1;
          end
        end
      end

      default: begin
        mode_d      = ModeFault;
        ns_d        = LampRed;
        ew_d        = LampRed;
        fault_d     = 1'b1;
        blink_cnt_d = BlinkInit;
      end
    endcase
  end

  // State and output registers; reset drives lamps all-red immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= ModeStart;
      prev_q      <= 2'd0;
      clr_cnt_q   <= ClrInit;
      blink_cnt_q <= 8'd0;
      ns_q        <= LampRed;
      ew_q        <= LampRed;
      fault_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      prev_q      <= prev_d;
      clr_cnt_q   <= clr_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      ns_q        <= ns_d;
      ew_q        <= ew_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.ns_lamp = ns_q;
  assign bus.ew_lamp = ew_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_traffic_light_driver.sv
// Bench for traffic_light_driver: a default build (2 clearance cycles, blink 4)
// and a zero-clearance build, both checked through an expected/observed scoreboard.
module tb_traffic_light_driver;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       f;
    string      tag;
  } item_t;

  logic clk;
  logic rst_a;
  logic rst_z;

  item_t exp_q[$];
  item_t obs_q[$];
  int    n_cmp;
  int    n_bad;

  traffic_light_driver_if bus_a ();
  traffic_light_driver_if bus_z ();

  traffic_light_driver #(
    .ALL_RED_CYCLES(2),
    .BLINK_HALF    (4)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
  );

  traffic_light_driver #(
    .ALL_RED_CYCLES(0),
    .BLINK_HALF    (4)
  ) dut_z (
    .clk(clk),
    .rst(rst_z),
    .bus(bus_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Push an expectation.
  task automatic expect_lamps(input logic [2:0] ns, input logic [2:0] ew, input logic f,
                              input string tag);
    item_t e;
    e.ns = ns; e.ew = ew; e.f = f; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Capture the current outputs of one DUT into the observed queue.
  task automatic snap(input bit zdut, input string tag);
    item_t o;
    if (zdut) begin
      o.ns = bus_z.ns_lamp; o.ew = bus_z.ew_lamp; o.f = bus_z.fault;
    end else begin
      o.ns = bus_a.ns_lamp; o.ew = bus_a.ew_lamp; o.f = bus_a.fault;
    end
    o.tag = tag;
    obs_q.push_back(o);
  endtask

  // Drive one cycle of stimulus, record what the lamps must show after the edge.
  task automatic apply(input bit zdut, input logic [1:0] st, input logic fc,
                       input logic [2:0] ens, input logic [2:0] eew, input logic ef,
                       input string tag);
    @(negedge clk);
    if (zdut) begin
      bus_z.state = st; bus_z.fault_clr = fc;
    end else begin
      bus_a.state = st; bus_a.fault_clr = fc;
    end
    expect_lamps(ens, eew, ef, tag);
    @(posedge clk);
    #1;
    snap(zdut, tag);
  endtask

  task automatic test_reset;
    item_t e, o;
    rst_a = 1'b1;
    rst_z = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    expect_lamps(RED, RED, 1'b0, "reset_a_held"); snap(1'b0, "reset_a_held");
    expect_lamps(RED, RED, 1'b0, "reset_z_held"); snap(1'b1, "reset_z_held");
    rst_a = 1'b0;
    rst_z = 1'b0;
    expect_lamps(RED, RED, 1'b0, "reset_a_release"); snap(1'b0, "reset_a_release");
    apply(1'b0, 2'd0, 1'b0, RED, RED, 1'b0, "reset_clear0");
    apply(1'b0, 2'd0, 1'b0, GRN, RED, 1'b0, "reset_ns_green0");
    apply(1'b0, 2'd0, 1'b0, GRN, RED, 1'b0, "reset_ns_green1");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.ns !== e.ns || o.ew !== e.ew || o.f !== e.f) begin
        n_bad++;
        $display("FAIL %s: got ns=%b ew=%b fault=%b, want ns=%b ew=%b fault=%b",
                 e.tag, o.ns, o.ew, o.f, e.ns, e.ew, e.f);
      end
    end
  endtask

  task automatic test_full_cycle;
    item_t e, o;
    for (int i = 0; i < 10; i++)
      apply(1'b0, 2'd1, 1'b0, YEL, RED, 1'b0, $sformatf("cyc_ns_yel[%0d]", i));
    for (int i = 0; i < 10; i++)
      apply(1'b0, 2'd2, 1'b0, RED, (i < 2) ? RED : GRN, 1'b0, $sformatf("cyc_ew_grn[%0d]", i));
    for (int i = 0; i < 10; i++)
      apply(1'b0, 2'd3, 1'b0, RED, YEL, 1'b0, $sformatf("cyc_ew_yel[%0d]", i));
    for (int i = 0; i < 10; i++)
      apply(1'b0, 2'd0, 1'b0, (i < 2) ? RED : GRN, RED, 1'b0, $sformatf("cyc_ns_grn[%0d]", i));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.ns !== e.ns || o.ew !== e.ew || o.f !== e.f) begin
        n_bad++;
        $display("FAIL %s: got ns=%b ew=%b fault=%b, want ns=%b ew=%b fault=%b",
                 e.tag, o.ns, o.ew, o.f, e.ns, e.ew, e.f);
      end
    end
  endtask

  task automatic test_fault_blink_clear;
    item_t e, o;
    logic [2:0] red;
    // Illegal 0->2, then blink; fault_clr at i=12 is ignored because state=1.
    for (int i = 0; i < 20; i++) begin
      red = (((i / 4) % 2) == 0) ? RED : OFF;
      apply(1'b0, (i < 12) ? 2'd2 : 2'd1, (i == 12), red, red, 1'b1,
            $sformatf("blink[%0d]", i));
    end
    apply(1'b0, 2'd0, 1'b1, RED, RED, 1'b0, "fault_exit");
    apply(1'b0, 2'd0, 1'b0, RED, RED, 1'b0, "exit_clear1");
    apply(1'b0, 2'd0, 1'b0, GRN, RED, 1'b0, "exit_ns_green");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.ns !== e.ns || o.ew !== e.ew || o.f !== e.f) begin
        n_bad++;
        $display("FAIL %s: got ns=%b ew=%b fault=%b, want ns=%b ew=%b fault=%b",
                 e.tag, o.ns, o.ew, o.f, e.ns, e.ew, e.f);
      end
    end
  endtask

  task automatic test_async_reset_clear;
    item_t e, o;
    apply(1'b0, 2'd1, 1'b0, YEL, RED, 1'b0, "arc_ns_yel");
    apply(1'b0, 2'd2, 1'b0, RED, RED, 1'b0, "arc_clear_entry");
    #2;
    rst_a = 1'b1;
    #1;
    expect_lamps(RED, RED, 1'b0, "arc_async"); snap(1'b0, "arc_async");
    bus_a.state = 2'd0;
    bus_a.fault_clr = 1'b0;
    rst_a = 1'b0;
    apply(1'b0, 2'd0, 1'b0, RED, RED, 1'b0, "arc_clear_restart");
    apply(1'b0, 2'd0, 1'b0, GRN, RED, 1'b0, "arc_ns_green");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.ns !== e.ns || o.ew !== e.ew || o.f !== e.f) begin
        n_bad++;
        $display("FAIL %s: got ns=%b ew=%b fault=%b, want ns=%b ew=%b fault=%b",
                 e.tag, o.ns, o.ew, o.f, e.ns, e.ew, e.f);
      end
    end
  endtask

  task automatic test_async_reset_fault;
    item_t e, o;
    for (int i = 0; i < 4; i++)
      apply(1'b0, 2'd2, 1'b0, RED, RED, 1'b1, $sformatf("arf_on[%0d]", i));
    apply(1'b0, 2'd2, 1'b0, OFF, OFF, 1'b1, "arf_off");
    #2;
    rst_a = 1'b1;
    #1;
    expect_lamps(RED, RED, 1'b0, "arf_async"); snap(1'b0, "arf_async");
    bus_a.state = 2'd0;
    rst_a = 1'b0;
    apply(1'b0, 2'd0, 1'b0, RED, RED, 1'b0, "arf_clear");
    apply(1'b0, 2'd0, 1'b0, GRN, RED, 1'b0, "arf_ns_green");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.ns !== e.ns || o.ew !== e.ew || o.f !== e.f) begin
        n_bad++;
        $display("FAIL %s: got ns=%b ew=%b fault=%b, want ns=%b ew=%b fault=%b",
                 e.tag, o.ns, o.ew, o.f, e.ns, e.ew, e.f);
      end
    end
  endtask

  task automatic test_zero_clear;
    item_t e, o;
    apply(1'b1, 2'd1, 1'b0, YEL, RED, 1'b0, "z_ns_yel");
    apply(1'b1, 2'd2, 1'b0, RED, GRN, 1'b0, "z_ew_green_direct");
    apply(1'b1, 2'd3, 1'b0, RED, YEL, 1'b0, "z_ew_yel");
    apply(1'b1, 2'd0, 1'b0, GRN, RED, 1'b0, "z_ns_green_direct");
    apply(1'b1, 2'd3, 1'b0, RED, RED, 1'b1, "z_illegal");
    apply(1'b1, 2'd0, 1'b1, GRN, RED, 1'b0, "z_fault_exit_run");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.ns !== e.ns || o.ew !== e.ew || o.f !== e.f) begin
        n_bad++;
        $display("FAIL %s: got ns=%b ew=%b fault=%b, want ns=%b ew=%b fault=%b",
                 e.tag, o.ns, o.ew, o.f, e.ns, e.ew, e.f);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_a = 1'b1;
    rst_z = 1'b1;
    bus_a.state = 2'd0;
    bus_a.fault_clr = 1'b0;
    bus_z.state = 2'd0;
    bus_z.fault_clr = 1'b0;
    test_reset();
    test_full_cycle();
    test_fault_blink_clear();
    test_async_reset_clear();
    test_async_reset_fault();
    test_zero_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
